// File: rtl/core_run_ctrl.sv
// Run-control sequencer for the core clock: decides each sys_clk cycle whether
// the core gets an edge (free-run, halt, N-cycle step, PC breakpoint, timed reset).
module core_run_ctrl #(
  parameter int STEP_W       = 16,
  parameter int RESET_CYCLES = 4,
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_count,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  output logic              clk_en,
  output logic              core_reset,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [STEP_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    S_HALTED,
    S_RUNNING,
    S_STEPPING,
    S_RESETTING
  } state_t;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_HALT = 2'd1;
  localparam logic [1:0] CAUSE_STEP = 2'd2;
  localparam logic [1:0] CAUSE_BP   = 2'd3;

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam state_t INIT_STATE = RUN_ON_RESET ? S_RUNNING : S_HALTED;

  state_t           state;
  logic             skip_bp;
  logic [CNT_W-1:0] rst_cnt;
  logic             bp_hit;
  logic             cmd_fire;

  assign cmd_ready  = (state != S_RESETTING);
  assign halted     = (state == S_HALTED);
  assign core_reset = (state == S_RESETTING);
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign bp_hit     = bp_en & (pc == bp_addr) & ~skip_bp;

  // NOTE: every branch of a combinational block must assign its outputs;
  // the default up front keeps synthesis from inferring a latch.
  always_comb begin
    clk_en = 1'b0;
    case (state)
      S_RUNNING:   clk_en = ~bp_hit;
      S_STEPPING:  clk_en = 1'b1;
      S_RESETTING: clk_en = 1'b1;
      default:     clk_en = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= INIT_STATE;
      skip_bp    <= 1'b1;
      rst_cnt    <= '0;
      steps_left <= '0;
      halt_cause <= CAUSE_NONE;
    end else begin
      case (state)
        S_HALTED: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_RUN: begin
                state   <= S_RUNNING;
                skip_bp <= 1'b1;
              end
              OP_STEP: begin
                if (cmd_count != '0) begin
                  state      <= S_STEPPING;
                  steps_left <= cmd_count;
                end
              end
              OP_RESET: begin
                state   <= S_RESETTING;
                rst_cnt <= RST_LOAD;
              end
              default: ;
            endcase
          end
        end

        S_RUNNING: begin
          // The breakpoint is masked only for the first cycle after a RUN.
          skip_bp <= 1'b0;
          if (cmd_fire && cmd_op == OP_RESET) begin
            state   <= S_RESETTING;
            rst_cnt <= RST_LOAD;
          end else if (bp_hit) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_BP;
          end else if (cmd_fire && cmd_op == OP_HALT) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_HALT;
          end
        end

        S_STEPPING: begin
          if (cmd_fire && cmd_op == OP_RESET) begin
            state      <= S_RESETTING;
            rst_cnt    <= RST_LOAD;
            steps_left <= '0;
          end else if (cmd_fire && cmd_op == OP_HALT) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_HALT;
            steps_left <= '0;
          end else if (steps_left == STEP_W'(1)) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_STEP;
            steps_left <= '0;
          end else begin
            steps_left <= steps_left - STEP_W'(1);
          end
        end

        S_RESETTING: begin
          if (rst_cnt == '0) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_NONE;
            steps_left <= '0;
          end else begin
            rst_cnt <= rst_cnt - CNT_W'(1);
          end
        end

        default: state <= INIT_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: directed scenarios plus a randomized
// run compared cycle-by-cycle against a behavioural model of the run modes.
module tb_core_run_ctrl;

  localparam int STEP_W       = 16;
  localparam int RESET_CYCLES = 4;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  logic              sys_clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_count;
  logic              bp_en;
  logic [31:0]       bp_addr;
  logic [31:0]       pc;
  logic              clk_en;
  logic              core_reset;
  logic              halted;
  logic [1:0]        halt_cause;
  logic [STEP_W-1:0] steps_left;

  int n_checks = 0;
  int n_errors = 0;

  core_run_ctrl #(
    .STEP_W(STEP_W), .RESET_CYCLES(RESET_CYCLES), .RUN_ON_RESET(1'b1)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .clk_en(clk_en), .core_reset(core_reset), .halted(halted),
    .halt_cause(halt_cause), .steps_left(steps_left)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic next_cycle();
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HALT; cmd_count = '0;
    bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0;
    next_cycle(); next_cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL reset_clk_en got=%b exp=1", clk_en); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (core_reset !== 1'b0) begin n_errors++; $display("FAIL reset_core_reset got=%b exp=0", core_reset); end
    n_checks++; if (halt_cause !== 2'd0) begin n_errors++; $display("FAIL reset_cause got=%0d exp=0", halt_cause); end
    n_checks++; if (steps_left !== '0) begin n_errors++; $display("FAIL reset_steps got=%0d exp=0", steps_left); end
  endtask

  task automatic test_halt();
    next_cycle();
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1;
    n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL halt_accept_edge got=%b exp=1", clk_en); end
    next_cycle();
    cmd_valid = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_halted got=%b exp=1", halted); end
    n_checks++; if (halt_cause !== 2'd1) begin n_errors++; $display("FAIL halt_cause got=%0d exp=1", halt_cause); end
    n_checks++; if (clk_en !== 1'b0) begin n_errors++; $display("FAIL halt_clk_en got=%b exp=0", clk_en); end
  endtask

  task automatic test_step();
    next_cycle();
    cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_count = 16'd5;
    #1;
    n_checks++; if (clk_en !== 1'b0) begin n_errors++; $display("FAIL step_cmd_clk_en got=%b exp=0", clk_en); end
    next_cycle();
    cmd_valid = 1'b0;
    for (int i = 5; i >= 1; i--) begin
      #1;
      n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL step_clk_en[%0d] got=%b exp=1", i, clk_en); end
      n_checks++; if (steps_left !== STEP_W'(i)) begin n_errors++; $display("FAIL step_left got=%0d exp=%0d", steps_left, i); end
      next_cycle();
    end
    #1;
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL step_done_halted got=%b exp=1", halted); end
    n_checks++; if (halt_cause !== 2'd2) begin n_errors++; $display("FAIL step_done_cause got=%0d exp=2", halt_cause); end
    n_checks++; if (steps_left !== '0) begin n_errors++; $display("FAIL step_done_left got=%0d exp=0", steps_left); end
    n_checks++; if (clk_en !== 1'b0) begin n_errors++; $display("FAIL step_done_clk_en got=%b exp=0", clk_en); end
    // A zero-count step is a no-op.
    cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_count = '0;
    next_cycle();
    cmd_valid = 1'b0;
    #1;
    n_checks++; if (clk_en !== 1'b0) begin n_errors++; $display("FAIL step0_clk_en got=%b exp=0", clk_en); end
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL step0_halted got=%b exp=1", halted); end
    n_checks++; if (halt_cause !== 2'd2) begin n_errors++; $display("FAIL step0_cause got=%0d exp=2", halt_cause); end
  endtask

  task automatic test_breakpoint();
    next_cycle();
    bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h8;
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    next_cycle();
    cmd_valid = 1'b0;
    #1;
    n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL bp_pc8_clk_en got=%b exp=1", clk_en); end
    next_cycle();
    pc = 32'hC;
    #1;
    n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL bp_pcC_clk_en got=%b exp=1", clk_en); end
    next_cycle();
    pc = 32'h10;
    #1;
    n_checks++; if (clk_en !== 1'b0) begin n_errors++; $display("FAIL bp_hit_clk_en got=%b exp=0", clk_en); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL bp_hit_halted got=%b exp=0", halted); end
    next_cycle();
    #1;
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL bp_after_halted got=%b exp=1", halted); end
    n_checks++; if (halt_cause !== 2'd3) begin n_errors++; $display("FAIL bp_after_cause got=%0d exp=3", halt_cause); end
    // Resume with pc still on the breakpoint: the first running cycle gets an edge.
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    next_cycle();
    cmd_valid = 1'b0;
    #1;
    n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL bp_resume_clk_en got=%b exp=1", clk_en); end
    next_cycle();
    pc = 32'h14;
    #1;
    n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL bp_resume2_clk_en got=%b exp=1", clk_en); end
    next_cycle();
    #1;
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL bp_no_rehalt got=%b exp=0", halted); end
  endtask

  task automatic test_halt_bp();
    next_cycle();
    pc = 32'h10; cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1;
    n_checks++; if (clk_en !== 1'b0) begin n_errors++; $display("FAIL haltbp_clk_en got=%b exp=0", clk_en); end
    next_cycle();
    cmd_valid = 1'b0; bp_en = 1'b0; pc = 32'h20;
    #1;
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL haltbp_halted got=%b exp=1", halted); end
    n_checks++; if (halt_cause !== 2'd3) begin n_errors++; $display("FAIL haltbp_cause got=%0d exp=3", halt_cause); end
  endtask

  task automatic test_reset_cmd();
    next_cycle();
    cmd_valid = 1'b1; cmd_op = OP_RESET;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rstcmd_ready got=%b exp=1", cmd_ready); end
    next_cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < RESET_CYCLES; i++) begin
      if (i == 1) begin cmd_valid = 1'b1; cmd_op = OP_RUN; end
      if (i == 2) cmd_valid = 1'b0;
      #1;
      n_checks++; if (core_reset !== 1'b1) begin n_errors++; $display("FAIL rstcmd_core_reset[%0d] got=%b exp=1", i, core_reset); end
      n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL rstcmd_clk_en[%0d] got=%b exp=1", i, clk_en); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rstcmd_busy[%0d] got=%b exp=0", i, cmd_ready); end
      next_cycle();
    end
    #1;
    n_checks++; if (core_reset !== 1'b0) begin n_errors++; $display("FAIL rstcmd_done_core_reset got=%b exp=0", core_reset); end
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL rstcmd_done_halted got=%b exp=1", halted); end
    n_checks++; if (halt_cause !== 2'd0) begin n_errors++; $display("FAIL rstcmd_done_cause got=%0d exp=0", halt_cause); end
    next_cycle();
    #1;
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL rstcmd_run_ignored got=%b exp=1", halted); end
  endtask

  task automatic test_reset_mid_step();
    next_cycle();
    bp_en = 1'b0; cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_count = 16'd10;
    next_cycle();
    cmd_valid = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    n_checks++; if (steps_left !== 16'd8) begin n_errors++; $display("FAIL midstep_left got=%0d exp=8", steps_left); end
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (steps_left !== '0) begin n_errors++; $display("FAIL midstep_abort_left got=%0d exp=0", steps_left); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL midstep_abort_halted got=%b exp=0", halted); end
    n_checks++; if (core_reset !== 1'b0) begin n_errors++; $display("FAIL midstep_abort_core_reset got=%b exp=0", core_reset); end
    n_checks++; if (clk_en !== 1'b1) begin n_errors++; $display("FAIL midstep_abort_clk_en got=%b exp=1", clk_en); end
  endtask

  // Behavioural model: the core is in one of four modes; a step grants a budget
  // of edges, a reset command holds the core for a fixed number of cycles.
  task automatic test_random();
    string mode;
    int    budget, hold_left, cause;
    bit    just_resumed, hit, accept;
    bit    e_clk, e_ready;

    next_cycle();
    reset = 1'b1; cmd_valid = 1'b0;
    next_cycle();
    reset = 1'b0;
    mode = "run"; budget = 0; hold_left = 0; cause = 0; just_resumed = 1'b1;
    bp_addr = 32'h0000_0040;

    for (int cyc = 0; cyc < 400; cyc++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_count = STEP_W'($urandom_range(0, 6));
      bp_en     = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    pc = bp_addr;
        2:       pc = bp_addr + 32'd4;
        default: pc = $urandom;
      endcase

      hit     = bp_en && (pc == bp_addr) && !just_resumed;
      e_ready = (mode != "hold");
      e_clk   = (mode == "step") || (mode == "hold") || (mode == "run" && !hit);
      accept  = cmd_valid && e_ready;
      #1;
      n_checks++; if (clk_en !== e_clk) begin n_errors++; $display("FAIL rnd_clk_en cyc=%0d got=%b exp=%b", cyc, clk_en, e_clk); end
      n_checks++; if (cmd_ready !== e_ready) begin n_errors++; $display("FAIL rnd_cmd_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, e_ready); end
      n_checks++; if (halted !== (mode == "halt")) begin n_errors++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", cyc, halted, mode == "halt"); end
      n_checks++; if (core_reset !== (mode == "hold")) begin n_errors++; $display("FAIL rnd_core_reset cyc=%0d got=%b exp=%b", cyc, core_reset, mode == "hold"); end
      n_checks++; if (halt_cause !== 2'(cause)) begin n_errors++; $display("FAIL rnd_cause cyc=%0d got=%0d exp=%0d", cyc, halt_cause, cause); end
      n_checks++; if (steps_left !== STEP_W'(budget)) begin n_errors++; $display("FAIL rnd_steps cyc=%0d got=%0d exp=%0d", cyc, steps_left, budget); end

      if (mode == "halt") begin
        if (accept && cmd_op == OP_RUN) begin mode = "run"; just_resumed = 1'b1; end
        else if (accept && cmd_op == OP_STEP && cmd_count != 0) begin mode = "step"; budget = int'(cmd_count); end
        else if (accept && cmd_op == OP_RESET) begin mode = "hold"; hold_left = RESET_CYCLES; end
      end else if (mode == "run") begin
        just_resumed = 1'b0;
        if (accept && cmd_op == OP_RESET) begin mode = "hold"; hold_left = RESET_CYCLES; end
        else if (hit) begin mode = "halt"; cause = 3; end
        else if (accept && cmd_op == OP_HALT) begin mode = "halt"; cause = 1; end
      end else if (mode == "step") begin
        if (accept && cmd_op == OP_RESET) begin mode = "hold"; hold_left = RESET_CYCLES; budget = 0; end
        else if (accept && cmd_op == OP_HALT) begin mode = "halt"; cause = 1; budget = 0; end
        else begin
          budget--;
          if (budget == 0) begin mode = "halt"; cause = 2; end
        end
      end else begin
        hold_left--;
        if (hold_left == 0) begin mode = "halt"; cause = 0; budget = 0; end
      end
      next_cycle();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_halt();
    test_step();
    test_breakpoint();
    test_halt_bp();
    test_reset_cmd();
    test_reset_mid_step();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
